uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one UART transmitter between two byte-stream clients. The block takes the 16x-oversampling `tick` from the baud-rate generator and arbitrates round-robin between two valid/ready channels. It serialises each granted byte as an 8N1 frame on `tx`. It sits between the on-chip producers (e.g. command responder and debug logger) and the UART pin.

## Interface
Parameters:
- DATA_W, 8, payload bits per frame, sent LSB first.
- OVS, 16, ticks per bit period; must match the generator's oversampling factor.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-clk pulse at baud*OVS rate from the baud-rate generator
- valid  in  2  per-channel request; bit i belongs to channel i
- data0  in  DATA_W  channel 0 byte; sampled on handshake
- data1  in  DATA_W  channel 1 byte; sampled on handshake
- ready  out  2  per-channel accept, at most one bit high
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress (state != IDLE)
- chan  out  1  index of channel owning the current or last frame
- done  out  1  one-clk pulse when the stop bit completes

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `ready` is combinational.
  - Only one valid: that channel gets ready.
  - Both valid: the channel != `last` gets ready.
  - `last` resets to 1, so channel 0 wins the first tie.
- Handshake: transfer when valid[i] & ready[i] at a posedge. On that edge:
  - latch data_i into shift register;
  - chan <= i; last <= i;
  - tick_cnt <= 0; state <= START.
- START: tx=0. Count ticks; on a tick with tick_cnt==OVS-1: tick_cnt<=0, bit_cnt<=0, state<=DATA.
- DATA: tx=shift[0].
  - On each tick with tick_cnt==OVS-1: shift right by 1 and bit_cnt++.
  - On that same tick with bit_cnt==DATA_W-1: state<=STOP.
- STOP: tx=1. On a tick with tick_cnt==OVS-1: done<=1 for one clk, state<=IDLE.
- tick_cnt width is $clog2(OVS) and wraps to 0 on terminal tick. bit_cnt width is $clog2(DATA_W).
- `ready` is 0 in all states other than IDLE. valid held during a frame is queued, not lost.
- A `tick` arriving in the same cycle as the handshake is ignored; counting starts with the next tick.
- Reset (async, any state): state=IDLE, tx=1, busy=0, done=0, chan=0, last=1, counters=0, ready=0 while rst high. Reset mid-frame truncates the frame; tx returns high immediately.

## Timing
- tx falls on the clk edge that completes the handshake. There is no latency beyond that edge.
- Start bit length lies between (OVS-1) and OVS tick periods, depending on tick phase. Data and stop bits are exactly OVS tick periods each.
- Frame = 1+DATA_W+1 bit periods. With tick every P clks: start bit is 16P clks minus phase offset; 8N1 frame ≈ 160P clks.
- `done` asserts the clk after the final stop tick. The block is in IDLE that same cycle, so a pending valid can be accepted on the next edge. Back-to-back frames have ≥1 clk of idle-high.
- `tick` held high continuously counts one per clk; this is legal, for simulation speed-up.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, STOP);
  - constant `UART_OVS = 16`;
  - constant `UART_DATA_W = 8`.
- Natural sub-module: `rr_arbiter2`, a 2-way round-robin grant with `last` pointer and an update-enable. This keeps the arbitration testable independently of the serialiser.

## Test plan
- Reset, then valid=2'b01, data0=8'hA5, tick every 3 clks:
  - ready=01 for one clk;
  - tx = 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1;
  - each data/stop bit 48 clks;
  - done pulses once; chan=0.
- Both valid continuously, data0=8'h11, data1=8'h22 → frames alternate ch0, ch1, ch0; chan toggles; ready never 2'b11.
- valid=2'b10 only after reset → ch1 granted immediately despite last=1; next tie goes to ch0.
- Assert rst mid-DATA (bit 3) → tx=1, busy=0, state IDLE asynchronously; first post-reset frame is complete and correct.
- tick tied high, data0=8'hFF → frame is exactly 160 clks of bit time; start bit 16 clks low; done one clk after stop.
- valid dropped during a frame, re-raised after done → no spurious frame; new frame accepted on first IDLE edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame geometry.
package uart_pkg;

    localparam int UART_OVS    = 16;
    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the channel that was not served last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_enable,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    // Starts at 1 so channel 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// 8N1 UART transmitter shared round-robin between two valid/ready byte channels.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int OVS    = UART_OVS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        valid,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic [1:0]        ready,
    output logic              tx,
    output logic              busy,
    output logic              chan,
    output logic              done
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    uart_tx_state_t    r_state;
    uart_tx_state_t    w_stateNext;
    logic [TW-1:0]     r_tickCnt;
    logic [TW-1:0]     w_tickNext;
    logic [BW-1:0]     r_bitCnt;
    logic [BW-1:0]     w_bitNext;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shiftNext;
    logic              r_chan;
    logic              w_chanNext;
    logic              r_done;
    logic              w_doneNext;
    logic              r_tx;
    logic              w_txNext;
    logic [1:0]        w_grant;
    logic              w_enable;
    logic              w_fire;
    logic              w_termTick;

    // Grants are only offered while idle and never while reset is held.
    assign w_enable   = (r_state == IDLE) && !rst;
    assign w_fire     = |(valid & w_grant);
    assign w_termTick = tick && (r_tickCnt == TICK_LAST);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (valid),
        .i_enable (w_enable),
        .i_update (w_fire),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_stateNext = r_state;
        w_tickNext  = r_tickCnt;
        w_bitNext   = r_bitCnt;
        w_shiftNext = r_shift;
        w_chanNext  = r_chan;
        w_doneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    w_shiftNext = w_grant[1] ? data1 : data0;
                    w_chanNext  = w_grant[1];
                    w_tickNext  = '0;
                    w_stateNext = START;
                end
            end
            START: begin
                if (w_termTick) begin
                    w_tickNext  = '0;
                    w_bitNext   = '0;
                    w_stateNext = DATA;
                end else if (tick) begin
                    w_tickNext = r_tickCnt + 1'b1;
                end
            end
            DATA: begin
                if (w_termTick) begin
                    w_tickNext  = '0;
                    w_shiftNext = r_shift >> 1;
                    w_bitNext   = r_bitCnt + 1'b1;
                    if (r_bitCnt == BIT_LAST) begin
                        w_stateNext = STOP;
                    end
                end else if (tick) begin
                    w_tickNext = r_tickCnt + 1'b1;
                end
            end
            STOP: begin
                if (w_termTick) begin
                    w_tickNext  = '0;
                    w_doneNext  = 1'b1;
                    w_stateNext = IDLE;
                end else if (tick) begin
                    w_tickNext = r_tickCnt + 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase

        // tx is registered from the next state so the pin never glitches.
        case (w_stateNext)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[0];
            default: w_txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tickCnt <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_chan    <= 1'b0;
            r_done    <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_stateNext;
            r_tickCnt <= w_tickNext;
            r_bitCnt  <= w_bitNext;
            r_shift   <= w_shiftNext;
            r_chan    <= w_chanNext;
            r_done    <= w_doneNext;
            r_tx      <= w_txNext;
        end
    end

    assign ready = w_grant;
    assign tx    = r_tx;
    assign busy  = (r_state != IDLE);
    assign chan  = r_chan;
    assign done  = r_done;

endmodule
